// File: rtl/pifo_pkg.sv
// Shared types and helpers for the virtualized multi-port PIFO.
package pifo_pkg;

   localparam int unsigned PIFO_PTW   = 8;
   localparam int unsigned PIFO_MTW   = 0;
   localparam int unsigned PIFO_CTW   = 8;
   localparam int unsigned PIFO_LEVEL = 4;
   localparam int unsigned PIFO_DEPTH = 8;
   localparam int unsigned PIFO_TFD   = 4;
   localparam int unsigned PIFO_EW    = PIFO_PTW + PIFO_MTW;
   localparam int unsigned PIFO_TW    = (PIFO_LEVEL > 1) ? $clog2(PIFO_LEVEL) : 1;
   localparam int unsigned PIFO_MAXD  = 64;

   // Encoded so that {pop, push} maps directly onto the op.
   typedef enum logic [1:0] {
      OP_NONE    = 2'd0,
      OP_PUSH    = 2'd1,
      OP_POP     = 2'd2,
      OP_PUSHPOP = 2'd3
   } task_op_e;

   typedef struct packed {
      task_op_e               op;
      logic [PIFO_TW-1:0]     tree;
      logic [PIFO_EW-1:0]     data;
   } task_t;

   // First slot below cnt holding a strictly larger priority; ties land after equals.
   function automatic int unsigned ins_idx(input logic [PIFO_MAXD-1:0] gt_mask,
                                           input int unsigned          cnt);
      int unsigned idx;
      logic        found;
      idx   = cnt;
      found = 1'b0;
      for (int unsigned i = 0; i < PIFO_MAXD; i++) begin
         if (!found && gt_mask[i] && (i < cnt)) begin
            idx   = i;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/pifo_sram_if.sv
// Request/response bundle between the port clients and pifo_sram_top.
interface pifo_sram_if
   import pifo_pkg::*;
#(
   parameter int unsigned LEVEL = PIFO_LEVEL,
   parameter int unsigned EW    = PIFO_EW,
   parameter int unsigned TW    = PIFO_TW
) ();

   logic [TW-1:0]    i_tree_id        [LEVEL];
   logic [LEVEL-1:0] i_push;
   logic [EW-1:0]    i_push_data      [LEVEL];
   logic [LEVEL-1:0] i_pop;
   logic [EW-1:0]    o_pop_data       [LEVEL];
   logic [LEVEL-1:0] o_task_fifo_full;

   modport master (
      output i_tree_id, i_push, i_push_data, i_pop,
      input  o_pop_data, o_task_fifo_full
   );

   modport slave (
      input  i_tree_id, i_push, i_push_data, i_pop,
      output o_pop_data, o_task_fifo_full
   );

endinterface

// File: rtl/pifo_task_fifo.sv
// Per-port task FIFO (power-of-two depth) with registered full/empty flags.
module pifo_task_fifo
   import pifo_pkg::*;
#(
   parameter type         T   = task_t,
   parameter int unsigned TFD = PIFO_TFD
) (
   input  logic i_clk,
   input  logic i_arst,
   input  logic i_wr,
   input  T     i_wdata,
   input  logic i_rd,
   output T     o_rdata_c,
   output logic o_empty,
   output logic o_full
);

   localparam int unsigned PW = (TFD > 1) ? $clog2(TFD) : 1;
   localparam int unsigned CW = $clog2(TFD + 1);

   T              mem_q [TFD];
   T              mem_d [TFD];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          empty_q, empty_d, full_q, full_d;
   logic          wr_ok, rd_ok;

   // Writes into a full FIFO are dropped; reads of an empty FIFO are ignored.
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      wr_ok  = i_wr && !full_q;
      rd_ok  = i_rd && !empty_q;
      if (wr_ok) begin
         mem_d[wptr_q] = i_wdata;
         wptr_d        = wptr_q + PW'(1);
      end
      if (rd_ok) begin
         rptr_d = rptr_q + PW'(1);
      end
      cnt_d   = cnt_q + CW'(wr_ok) - CW'(rd_ok);
      empty_d = (cnt_d == '0);
      full_d  = (cnt_d == CW'(TFD));
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         empty_q <= empty_d;
         full_q  <= full_d;
      end
   end

   assign o_rdata_c = mem_q[rptr_q];
   assign o_empty   = empty_q;
   assign o_full    = full_q;

endmodule

// File: rtl/pifo_sram_top.sv
// Multi-port virtualized PIFO: LEVEL task FIFOs, round-robin scheduler, one shared sorted store.
// Define PIFO_SVA_EN to compile in the internal consistency assertions.
module pifo_sram_top
   import pifo_pkg::*;
#(
   parameter int unsigned PTW   = PIFO_PTW,
   parameter int unsigned MTW   = PIFO_MTW,
   parameter int unsigned CTW   = PIFO_CTW,
   parameter int unsigned LEVEL = PIFO_LEVEL,
   parameter int unsigned DEPTH = PIFO_DEPTH,
   parameter int unsigned TFD   = PIFO_TFD
) (
   input  logic        i_clk,
   input  logic        i_arst,
   pifo_sram_if.slave  bus
);

   localparam int unsigned EW = PTW + MTW;
   localparam int unsigned TW = (LEVEL > 1) ? $clog2(LEVEL) : 1;
   localparam int unsigned NE = LEVEL * DEPTH;
   localparam int unsigned AW = (NE > 1) ? $clog2(NE) : 1;

   typedef struct packed {
      task_op_e      op;
      logic [TW-1:0] tree;
      logic [EW-1:0] data;
   } ptask_t;

   ptask_t           wtask [LEVEL];
   ptask_t           head  [LEVEL];
   logic [LEVEL-1:0] empty, full, rd;

   logic [EW-1:0]    mem_q [NE];
   logic [EW-1:0]    mem_d [NE];
   logic [CTW-1:0]   cnt_q [LEVEL];
   logic [CTW-1:0]   cnt_d [LEVEL];
   logic [EW-1:0]    pop_q [LEVEL];
   logic [EW-1:0]    pop_d [LEVEL];
   logic [TW-1:0]    last_q, last_d;

   logic                 gnt_vld;
   logic [TW-1:0]        gnt, cand;
   ptask_t               tsk;
   int unsigned          base, cnt, ins;
   logic [PIFO_MAXD-1:0] gt;

   for (genvar p = 0; p < LEVEL; p++) begin : g_port
      assign wtask[p] = '{op:   task_op_e'({bus.i_pop[p], bus.i_push[p]}),
                          tree: bus.i_tree_id[p],
                          data: bus.i_push_data[p]};

      pifo_task_fifo #(.T(ptask_t), .TFD(TFD)) u_fifo (
         .i_clk     (i_clk),
         .i_arst    (i_arst),
         .i_wr      (bus.i_push[p] | bus.i_pop[p]),
         .i_wdata   (wtask[p]),
         .i_rd      (rd[p]),
         .o_rdata_c (head[p]),
         .o_empty   (empty[p]),
         .o_full    (full[p])
      );

      assign bus.o_pop_data[p] = pop_q[p];
   end

   assign bus.o_task_fifo_full = full;

   // Round-robin grant, then execute the granted task against its tree region.
   always_comb begin
      mem_d   = mem_q;
      cnt_d   = cnt_q;
      pop_d   = pop_q;
      last_d  = last_q;
      rd      = '0;
      gnt_vld = 1'b0;
      gnt     = '0;
      cand    = '0;
      tsk     = '0;
      base    = 0;
      cnt     = 0;
      ins     = 0;
      gt      = '0;

      for (int unsigned k = 1; k <= LEVEL; k++) begin
         cand = TW'((32'(last_q) + k) % LEVEL);
         if (!gnt_vld && !empty[cand]) begin
            gnt_vld = 1'b1;
            gnt     = cand;
         end
      end

      if (gnt_vld) begin
         rd[gnt] = 1'b1;
         last_d  = gnt;
         tsk     = head[gnt];
         if (32'(tsk.tree) < LEVEL) begin
            base = 32'(tsk.tree) * DEPTH;
            cnt  = 32'(cnt_q[tsk.tree]);
            for (int unsigned i = 0; i < DEPTH; i++) begin
               gt[i] = mem_q[AW'(base + i)][EW-1 -: PTW] > tsk.data[EW-1 -: PTW];
            end
            ins = ins_idx(gt, cnt);
            case (tsk.op)
               OP_PUSH: begin
                  if (cnt < DEPTH) begin
                     for (int unsigned i = 1; i < DEPTH; i++) begin
                        if (i > ins) mem_d[AW'(base + i)] = mem_q[AW'(base + i - 1)];
                     end
                     mem_d[AW'(base + ins)] = tsk.data;
                     cnt_d[tsk.tree]        = cnt_q[tsk.tree] + CTW'(1);
                  end
               end
               OP_POP: begin
                  if (cnt == 0) begin
                     pop_d[gnt] = '0;
                  end else begin
                     pop_d[gnt] = mem_q[AW'(base)];
                     for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                        mem_d[AW'(base + i)] = mem_q[AW'(base + i + 1)];
                     end
                     cnt_d[tsk.tree] = cnt_q[tsk.tree] - CTW'(1);
                  end
               end
               OP_PUSHPOP: begin
                  if ((cnt == 0) || (tsk.data[EW-1 -: PTW] < mem_q[AW'(base)][EW-1 -: PTW])) begin
                     pop_d[gnt] = tsk.data;
                  end else begin
                     // Head leaves; ins >= 1 here, so the new entry lands at ins-1 after the shift.
                     pop_d[gnt] = mem_q[AW'(base)];
                     for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                        if (i + 1 < ins) mem_d[AW'(base + i)] = mem_q[AW'(base + i + 1)];
                     end
                     mem_d[AW'(base + ins - 1)] = tsk.data;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         mem_q  <= '{default: '0};
         cnt_q  <= '{default: '0};
         pop_q  <= '{default: '0};
         last_q <= TW'(LEVEL - 1);
      end else begin
         mem_q  <= mem_d;
         cnt_q  <= cnt_d;
         pop_q  <= pop_d;
         last_q <= last_d;
      end
   end

`ifdef PIFO_SVA_EN
   logic sorted_ok, occ_ok;

   always_comb begin
      sorted_ok = 1'b1;
      occ_ok    = 1'b1;
      for (int unsigned t = 0; t < LEVEL; t++) begin
         if (32'(cnt_q[t]) > DEPTH) occ_ok = 1'b0;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if ((32'(cnt_q[t]) > i) &&
                (mem_q[AW'(t * DEPTH + i - 1)][EW-1 -: PTW] > mem_q[AW'(t * DEPTH + i)][EW-1 -: PTW]))
               sorted_ok = 1'b0;
         end
      end
   end

   a_fifo_ovf: assert property (@(posedge i_clk) disable iff (i_arst)
                                (((bus.i_push | bus.i_pop) & full) == '0));
   a_occ:      assert property (@(posedge i_clk) disable iff (i_arst) occ_ok);
   a_sorted:   assert property (@(posedge i_clk) disable iff (i_arst) sorted_ok);
   a_one_task: assert property (@(posedge i_clk) disable iff (i_arst) $onehot0(rd));
`endif

endmodule

// File: tb/tb_pifo_sram_top.sv
// Randomized and directed bench for pifo_sram_top against a queue-based reference model.
module tb_pifo_sram_top;

   localparam int LEVEL = 4;
   localparam int DEPTH = 8;
   localparam int TFD   = 4;

   logic clk  = 1'b0;
   logic arst = 1'b1;

   always #5 clk = ~clk;

   pifo_sram_if #(.LEVEL(LEVEL), .EW(8), .TW(2)) bus ();

   pifo_sram_top #(.PTW(8), .MTW(0), .CTW(8), .LEVEL(LEVEL), .DEPTH(DEPTH), .TFD(TFD)) dut (
      .i_clk  (clk),
      .i_arst (arst),
      .bus    (bus)
   );

   typedef struct {
      int op;
      int tree;
      int data;
   } mtask_t;

   mtask_t fq [LEVEL][$];
   int     tq [LEVEL][$];
   int     exp_pop [LEVEL];
   int     last;
   int     n_tests = 0;
   int     n_fail  = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int p = 0; p < LEVEL; p++) begin
         fq[p].delete();
         tq[p].delete();
         exp_pop[p] = 0;
      end
      last = LEVEL - 1;
   endfunction

   function automatic void tree_insert(input int t, input int d);
      int pos = tq[t].size();
      for (int i = tq[t].size() - 1; i >= 0; i--) begin
         if (tq[t][i] > d) pos = i;
      end
      tq[t].insert(pos, d);
   endfunction

   function automatic void exec(input int p, input mtask_t t);
      if (t.tree >= LEVEL) return;
      case (t.op)
         1: if (tq[t.tree].size() < DEPTH) tree_insert(t.tree, t.data);
         2: if (tq[t.tree].size() == 0) exp_pop[p] = 0;
            else exp_pop[p] = tq[t.tree].pop_front();
         3: if (tq[t.tree].size() == 0 || t.data < tq[t.tree][0]) exp_pop[p] = t.data;
            else begin
               exp_pop[p] = tq[t.tree].pop_front();
               tree_insert(t.tree, t.data);
            end
         default: ;
      endcase
   endfunction

   // One clock edge: run one granted task, then capture new requests.
   function automatic void model_edge();
      bit     full_b [LEVEL];
      mtask_t t;
      for (int p = 0; p < LEVEL; p++) full_b[p] = (fq[p].size() == TFD);
      for (int k = 1; k <= LEVEL; k++) begin
         int j = (last + k) % LEVEL;
         if (fq[j].size() > 0) begin
            t    = fq[j].pop_front();
            last = j;
            exec(j, t);
            break;
         end
      end
      for (int p = 0; p < LEVEL; p++) begin
         if ((bus.i_push[p] || bus.i_pop[p]) && !full_b[p]) begin
            t.op   = (int'(bus.i_pop[p]) << 1) | int'(bus.i_push[p]);
            t.tree = int'(bus.i_tree_id[p]);
            t.data = int'(bus.i_push_data[p]);
            fq[p].push_back(t);
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      for (int p = 0; p < LEVEL; p++) begin
         chk($sformatf("pop_data[%0d]", p), int'(bus.o_pop_data[p]), exp_pop[p]);
         chk($sformatf("fifo_full[%0d]", p), int'(bus.o_task_fifo_full[p]), int'(fq[p].size() == TFD));
      end
   endtask

   task automatic idle();
      for (int p = 0; p < LEVEL; p++) begin
         bus.i_push[p]      = 1'b0;
         bus.i_pop[p]       = 1'b0;
         bus.i_tree_id[p]   = '0;
         bus.i_push_data[p] = '0;
      end
   endtask

   task automatic req(input int p, input bit push, input bit pop, input int t, input int d);
      bus.i_push[p]      = push;
      bus.i_pop[p]       = pop;
      bus.i_tree_id[p]   = 2'(t);
      bus.i_push_data[p] = 8'(d);
   endtask

   task automatic run(input int n);
      idle();
      repeat (n) tick();
   endtask

   task automatic pops(input int p, input int t, input int n);
      for (int i = 0; i < n; i++) begin
         idle();
         req(p, 1'b0, 1'b1, t, 0);
         tick();
      end
      run(3);
   endtask

   task automatic push1(input int p, input int t, input int d);
      idle();
      req(p, 1'b1, 1'b0, t, d);
      tick();
   endtask

   task automatic check_reset_outputs();
      for (int p = 0; p < LEVEL; p++) begin
         chk($sformatf("rst_pop_data[%0d]", p), int'(bus.o_pop_data[p]), 0);
         chk($sformatf("rst_fifo_full[%0d]", p), int'(bus.o_task_fifo_full[p]), 0);
      end
   endtask

   initial begin
      int vals [4];
      idle();
      model_reset();
      #2;
      check_reset_outputs();
      #10;
      arst = 1'b0;

      // Two ports feeding two trees concurrently, then interleaved pops/pushes.
      for (int c = 0; c < 5; c++) begin
         idle();
         req(0, 1'b1, 1'b0, 0, c + 1);
         if (c < 3) req(2, 1'b1, 1'b0, 2, c + 1);
         tick();
      end
      run(6);
      for (int c = 0; c < 3; c++) begin
         idle();
         req(2, 1'b0, 1'b1, 2, 0);
         req(0, 1'b1, 1'b0, 0, 6 + c);
         tick();
      end
      run(6);
      pops(1, 0, 9);

      // Out-of-order insert with a tie, then drain past empty.
      vals = '{5, 3, 9, 3};
      foreach (vals[i]) push1(1, 1, vals[i]);
      run(3);
      pops(1, 1, 5);

      // Overfill one tree.
      for (int i = 0; i < 9; i++) push1(3, 3, $urandom_range(0, 255));
      run(3);
      pops(3, 3, 9);

      // Every port pushes every cycle: FIFOs saturate and drop.
      for (int c = 0; c < 6; c++) begin
         idle();
         for (int p = 0; p < LEVEL; p++) req(p, 1'b1, 1'b0, p, $urandom_range(0, 255));
         tick();
      end
      run(20);
      for (int p = 0; p < LEVEL; p++) pops(p, p, 9);

      // PUSHPOP below and above the head.
      push1(0, 0, 4);
      push1(0, 0, 6);
      run(3);
      idle(); req(0, 1'b1, 1'b1, 0, 2); tick(); run(3);
      idle(); req(0, 1'b1, 1'b1, 0, 7); tick(); run(3);
      idle(); req(0, 1'b1, 1'b1, 0, 6); tick(); run(3);
      pops(0, 0, 3);

      // Reset while the FIFOs hold work.
      for (int c = 0; c < 4; c++) begin
         idle();
         for (int p = 0; p < LEVEL; p++) req(p, 1'b1, (c == 3), p, 10 + c);
         tick();
      end
      #3;
      arst = 1'b1;
      #1;
      check_reset_outputs();
      model_reset();
      @(posedge clk);
      #3;
      arst = 1'b0;
      idle();
      for (int p = 0; p < LEVEL; p++) pops(p, p, 1);

      // Random traffic with many ties.
      for (int c = 0; c < 500; c++) begin
         idle();
         for (int p = 0; p < LEVEL; p++) begin
            int r = $urandom_range(0, 19);
            int t = $urandom_range(0, LEVEL - 1);
            int d = $urandom_range(0, 31);
            if (r < 8)       req(p, 1'b1, 1'b0, t, d);
            else if (r < 13) req(p, 1'b0, 1'b1, t, d);
            else if (r < 15) req(p, 1'b1, 1'b1, t, d);
         end
         tick();
      end
      run(25);
      for (int p = 0; p < LEVEL; p++) pops(p, p, 9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
